// File: rtl/gw_prim_pkg.sv
// gw_prim_pkg: shared primitives for the gw_* clocking blocks.
//   phase_t     - 3-bit divider phase counter value
//   lockout_t   - 4-bit CALIB lockout counter value
//   DivModeList - divide ratios the clock divider supports
//   div_mode_legal() - elaboration-time membership test against DivModeList
package gw_prim_pkg;

  typedef logic [2:0] phase_t;
  typedef logic [3:0] lockout_t;

  localparam int unsigned NumDivModes = 4;
  localparam int unsigned DivModeList [NumDivModes] = '{2, 4, 5, 8};

  function automatic bit div_mode_legal(input int unsigned mode);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < NumDivModes; i++) begin
      if (DivModeList[i] == mode) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/gw_clkdiv_calib.sv
// gw_clkdiv_calib: CALIB rising-edge detector with lockout, producing a slip request.
// Only instantiated when GW_CLKDIV_CALIB_EN is defined.
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset
//   calib_i - phase-slip request level
//   slip_o  - one-cycle pulse: hold the divider for this cycle
module gw_clkdiv_calib
  import gw_prim_pkg::*;
#(
  parameter int unsigned LOCKOUT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic calib_i,
  output logic slip_o
);

  localparam lockout_t LkLoad = lockout_t'(LOCKOUT);

  logic     calib_q;
  logic     armed_q;
  lockout_t lk_q, lk_d;
  logic     calib_rise;

  assign calib_rise = calib_i & ~calib_q;
  // The first cycle out of reset is not armed: it only loads the lockout, so an
  // edge coincident with reset release is swallowed.
  assign slip_o     = calib_rise & armed_q & (lk_q == '0);

  always_comb begin
    lk_d = lk_q;
    if (!armed_q || slip_o) begin
      lk_d = LkLoad;
    end else if (lk_q != '0) begin
      lk_d = lk_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      calib_q <= 1'b0;
      armed_q <= 1'b0;
      lk_q    <= '0;
    end else begin
      calib_q <= calib_i;
      armed_q <= 1'b1;
      lk_q    <= lk_d;
    end
  end

endmodule

// File: rtl/gw_clkdiv.sv
// gw_clkdiv: integer clock divider (ratio 2/4/5/8) with optional CALIB phase slip.
// Build option: define GW_CLKDIV_CALIB_EN to enable CALIB handling; otherwise CALIB
// is accepted but ignored and the divider never slips.
//   CLK    - sole clock, rising edge
//   RESETN - asynchronous active-low reset
//   CALIB  - phase-slip request (rising edge)
//   CLKOUT - divided clock, straight from a flop
//   RDY    - high from the second counter wrap after reset
//   PHASE  - current phase counter
module gw_clkdiv
  import gw_prim_pkg::*;
#(
  parameter int unsigned DIV_MODE = 2,
  parameter int unsigned LOCKOUT  = 4
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       CALIB,
  output logic       CLKOUT,
  output logic       RDY,
  output logic [2:0] PHASE
);

  if (!div_mode_legal(DIV_MODE)) begin : g_bad_div_mode
    $error("gw_clkdiv: DIV_MODE %0d is not one of 2, 4, 5, 8", DIV_MODE);
  end
  if (LOCKOUT < 1 || LOCKOUT > 15) begin : g_bad_lockout
    $error("gw_clkdiv: LOCKOUT %0d outside 1..15", LOCKOUT);
  end

  localparam phase_t CntMax  = phase_t'(DIV_MODE - 1);
  localparam phase_t CntHalf = phase_t'(DIV_MODE / 2);

  logic   slip;
  phase_t cnt_q, cnt_d;
  logic   clkout_q, clkout_d;
  logic   wrap_seen_q, wrap_seen_d;
  logic   rdy_q, rdy_d;
  logic   wrap;

`ifdef GW_CLKDIV_CALIB_EN
  gw_clkdiv_calib #(
    .LOCKOUT (LOCKOUT)
  ) u_calib (
    .clk_i   (CLK),
    .rst_ni  (RESETN),
    .calib_i (CALIB),
    .slip_o  (slip)
  );
`else
  logic unused_calib;
  assign unused_calib = CALIB;
  assign slip         = 1'b0;
`endif

  assign wrap = ~slip & (cnt_q == CntMax);

  always_comb begin
    cnt_d       = cnt_q;
    clkout_d    = clkout_q;
    wrap_seen_d = wrap_seen_q | wrap;
    rdy_d       = rdy_q | (wrap & wrap_seen_q);
    if (!slip) begin
      cnt_d    = wrap ? '0 : cnt_q + 3'd1;
      // Register the level for the phase we are entering, so CLKOUT is a clean flop.
      clkout_d = (cnt_d < CntHalf);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q       <= CntMax;
      clkout_q    <= 1'b0;
      wrap_seen_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      clkout_q    <= clkout_d;
      wrap_seen_q <= wrap_seen_d;
      rdy_q       <= rdy_d;
    end
  end

  assign CLKOUT = clkout_q;
  assign RDY    = rdy_q;
  assign PHASE  = cnt_q;

endmodule

// File: tb/tb_gw_clkdiv.sv
// tb_gw_clkdiv: directed bench for gw_clkdiv at DIV_MODE 4, 5 and 8 side by side.
// With GW_CLKDIV_CALIB_EN defined the DIV_MODE=8 instance receives slip requests;
// otherwise CALIB toggles every cycle on all instances and must have no effect.
module tb_gw_clkdiv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, rst5, rst8;
  logic       cal4, cal5, cal8;
  logic       co4, co5, co8;
  logic       rdy4, rdy5, rdy8;
  logic [2:0] ph4, ph5, ph8;

  int n_vec = 0;
  int n_err = 0;

  gw_clkdiv #(.DIV_MODE(4), .LOCKOUT(4)) u_dut4 (
    .CLK(clk), .RESETN(rst4), .CALIB(cal4), .CLKOUT(co4), .RDY(rdy4), .PHASE(ph4)
  );
  gw_clkdiv #(.DIV_MODE(5), .LOCKOUT(4)) u_dut5 (
    .CLK(clk), .RESETN(rst5), .CALIB(cal5), .CLKOUT(co5), .RDY(rdy5), .PHASE(ph5)
  );
  gw_clkdiv #(.DIV_MODE(8), .LOCKOUT(4)) u_dut8 (
    .CLK(clk), .RESETN(rst8), .CALIB(cal8), .CLKOUT(co8), .RDY(rdy8), .PHASE(ph8)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Hand tables: CLKOUT after rise n is tbl[(n-1) % DIV_MODE].
  logic clk4_tbl [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic clk5_tbl [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  int   ph5_tbl  [5] = '{0, 1, 2, 3, 4};

  initial begin
    int exp8;
    rst4 = 1'b0; rst5 = 1'b0; rst8 = 1'b0;
    cal4 = 1'b0; cal5 = 1'b0; cal8 = 1'b0;
    repeat (2) @(negedge clk);

    check_eq("rst clkout4", 8'(co4), 8'd0);
    check_eq("rst rdy4",    8'(rdy4), 8'd0);
    check_eq("rst phase4",  8'(ph4), 8'd3);
    check_eq("rst phase5",  8'(ph5), 8'd4);
    check_eq("rst phase8",  8'(ph8), 8'd7);
    check_eq("rst clkout8", 8'(co8), 8'd0);

`ifdef GW_CLKDIV_CALIB_EN
    // Edge coincident with the first rise after release must be ignored.
    cal8 = 1'b1;
`endif
    rst4 = 1'b1; rst5 = 1'b1; rst8 = 1'b1;

    for (int n = 1; n <= 24; n++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("clkout4 r%0d", n), 8'(co4), 8'(clk4_tbl[(n-1)%4]));
      check_eq($sformatf("phase4 r%0d", n), 8'(ph4), 8'((n-1)%4));
      check_eq($sformatf("rdy4 r%0d", n), 8'(rdy4), 8'(n >= 5));
      if (n <= 10) begin
        check_eq($sformatf("clkout5 r%0d", n), 8'(co5), 8'(clk5_tbl[(n-1)%5]));
        check_eq($sformatf("phase5 r%0d", n), 8'(ph5), 8'(ph5_tbl[(n-1)%5]));
      end
`ifdef GW_CLKDIV_CALIB_EN
      // Accepted slips at rises 10 and 16; the edge at rise 12 is locked out.
      if (n < 10)      exp8 = (n - 1) % 8;
      else if (n < 16) exp8 = (n - 2) % 8;
      else             exp8 = (n - 3) % 8;
`else
      exp8 = (n - 1) % 8;
`endif
      check_eq($sformatf("phase8 r%0d", n), 8'(ph8), 8'(exp8));
      check_eq($sformatf("clkout8 r%0d", n), 8'(co8), 8'(exp8 < 4));
`ifdef GW_CLKDIV_CALIB_EN
      cal8 = (n == 9) || (n == 11) || (n == 15);
`else
      cal4 = ~cal4;
      cal5 = ~cal5;
      cal8 = ~cal8;
`endif
    end

    // Enter a CLKOUT high phase, then hit reset between clock edges.
    @(posedge clk);
    @(negedge clk);
    check_eq("pre-rst clkout4", 8'(co4), 8'd1);
    check_eq("pre-rst rdy4",    8'(rdy4), 8'd1);
    #2 rst4 = 1'b0;
    #1;
    check_eq("async clkout4", 8'(co4), 8'd0);
    check_eq("async rdy4",    8'(rdy4), 8'd0);
    check_eq("async phase4",  8'(ph4), 8'd3);
    @(negedge clk);
    rst4 = 1'b1;
    for (int m = 1; m <= 6; m++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("re clkout4 r%0d", m), 8'(co4), 8'(clk4_tbl[(m-1)%4]));
      check_eq($sformatf("re phase4 r%0d", m), 8'(ph4), 8'((m-1)%4));
      check_eq($sformatf("re rdy4 r%0d", m), 8'(rdy4), 8'(m >= 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gw_clkdiv.md
GW_CLKDIV -- requirements
Module: gw_clkdiv

Interface
REQ-001 SHALL have parameter DIV_MODE, default 2, output divide ratio; legal values 2, 4, 5, 8.
REQ-002 SHALL have parameter LOCKOUT, default 4, CLK cycles during which further CALIB edges are ignored after an accepted one; range 1..15.
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge active.
REQ-004 SHALL have port RESETN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port CALIB  input  1  phase-slip request; rising edge sampled on CLK.
REQ-006 SHALL have port CLKOUT  output  1  divided clock, driven directly from a register.
REQ-007 SHALL have port RDY  output  1  divider settled.
REQ-008 SHALL have port PHASE  output  3  current phase counter value.

Function
REQ-009 SHALL keep phase counter cnt (3 bits), advancing 0..DIV_MODE-1 on each CLK rise, then wrapping to 0.
REQ-010 SHALL register CLKOUT <= (cnt_next < DIV_MODE/2, integer floor): high 1/2/2/4 cycles and low 1/2/3/4 cycles for DIV_MODE 2/4/5/8.
REQ-011 SHALL make the first CLKOUT rise occur on the first CLK rise after RESETN deasserts, because cnt resets to DIV_MODE-1.
REQ-012 SHALL detect a CALIB rising edge as CALIB=1 while calib_q=0 at a CLK rise, where calib_q is CALIB registered once.
REQ-013 SHALL, on an accepted edge, hold cnt and CLKOUT for exactly that cycle, delaying the output phase by one CLK period.
REQ-014 SHALL load lockout counter lk with LOCKOUT on an accepted edge and decrement it each cycle; edges are accepted only when lk=0.
REQ-015 SHALL ignore an edge arriving while lk!=0 entirely: no slip, no reload of lk.
REQ-016 SHALL hold CALIB held high constant after its rising edge as a single event; no repeated slips.
REQ-017 SHALL set RDY at the CLK rise where cnt wraps to 0 for the second time after reset, then hold it high until reset.
REQ-018 SHALL NOT clear RDY on a slip.
REQ-019 SHALL treat an illegal DIV_MODE or LOCKOUT as an elaboration-time error.

Reset
REQ-020 SHALL, while RESETN=0, immediately force cnt=DIV_MODE-1, CLKOUT=0, RDY=0, calib_q=0, lk=0, PHASE=DIV_MODE-1.
REQ-021 SHALL, on RESETN asserted mid-period, truncate the CLKOUT high phase at once, with no glitch beyond the async clear.
REQ-022 SHALL give a CALIB edge coincident with the first CLK rise after reset release no effect, since calib_q starts at 0 but lk is forced to LOCKOUT out of reset.

Configuration
REQ-023 SHALL, with GW_CLKDIV_CALIB_EN defined, implement REQ-012..REQ-016 and REQ-022.
REQ-024 SHALL, with GW_CLKDIV_CALIB_EN undefined, keep the CALIB port but leave it unused: no edge detector, no lockout, never slips; all other behaviour unchanged.

Structure
REQ-025 SHALL take the legal DIV_MODE list, the 3-bit phase typedef and the 4-bit lockout typedef from shared package gw_prim_pkg.
REQ-026 SHALL place CALIB edge detection and lockout in sub-module gw_clkdiv_calib, which outputs a one-cycle slip pulse; it is instantiated only under GW_CLKDIV_CALIB_EN.

Verification
REQ-027 SHALL check DIV_MODE=4, reset released, 20 CLK -> CLKOUT 1,1,0,0 repeating from the first edge; RDY high at CLK rise 5.
REQ-028 SHALL check DIV_MODE=5 -> CLKOUT high 2 / low 3 cycles, PHASE sequence 0,1,2,3,4,0.
REQ-029 SHALL check DIV_MODE=8, LOCKOUT=4, CALIB pulse at cycle 10 -> PHASE repeats its value once, CLKOUT period 9 once, then 8.
REQ-030 SHALL check that a second CALIB edge 2 cycles after the first (LOCKOUT=4) causes no slip, while a third edge 6 cycles after the first slips.
REQ-031 SHALL check that RESETN pulsed low mid-high-phase drops CLKOUT and RDY to 0 asynchronously, with PHASE=DIV_MODE-1 before the next CLK.
REQ-032 SHALL check, built without GW_CLKDIV_CALIB_EN, that CALIB toggling every cycle leaves the CLKOUT period exactly DIV_MODE.
